dbus_wishbone_if: RTL and testbench

Data-side bus bridge between the memory-access stage and the external Wishbone data bus. Turns the stage's single-cycle load/store request (address, write enable, byte select, write data, chip enable) into a registered Wishbone classic cycle. Holds the pipeline with a stall request until the slave acknowledges. Returns load data to the memory-access stage, and aborts cleanly on pipeline flush (exception or ERET).

---
 rtl/cpu_defs.sv | 13 +
 rtl/dbus_watchdog.sv | 19 +
 rtl/dbus_wishbone_if.sv | 96 +++++++++
 tb/tb_dbus_wishbone_if.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared state encoding, widths and bus request record for the data-bus bridge
package cpu_defs;
    localparam int STALL_W = 6;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, HOLD = 2'b10} dbus_state_t;
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic [3:0] sel;
        logic we;
    } wb_req_t;
endpackage

// File: rtl/dbus_watchdog.sv
// dbus_watchdog: ack-wait counter; expire is high in the LIMIT-th enabled cycle after a clear
module dbus_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign expire = en && cnt == LAST;
endmodule

// File: rtl/dbus_wishbone_if.sv
// dbus_wishbone_if: memory-stage load/store to registered Wishbone classic cycle, with stall and flush.
// Define DBUS_TIMEOUT_EN to add the ack watchdog and the bus_err_o port.
module dbus_wishbone_if
    import cpu_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [WORD_W-1:0]  cpu_addr_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [WORD_W-1:0]  cpu_data_i,
    output logic [WORD_W-1:0]  cpu_data_o,
    output logic               stallreq_o,
    input  logic [WORD_W-1:0]  wb_data_i,
    input  logic               wb_ack_i,
    output logic [WORD_W-1:0]  wb_addr_o,
    output logic [WORD_W-1:0]  wb_data_o,
    output logic               wb_we_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o
`ifdef DBUS_TIMEOUT_EN
    ,
    output logic               bus_err_o
`endif
);
    dbus_state_t state, next;
    wb_req_t req_q;
    logic cyc;
    logic [WORD_W-1:0] rd_buf;
    logic start, done, expire;
    assign start = state == IDLE && cpu_ce_i && !flush_i;
    assign done = state == BUSY && !flush_i && (wb_ack_i || expire);
`ifdef DBUS_TIMEOUT_EN
    dbus_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk(clk),
        .rst(rst),
        .en(state == BUSY),
        .clr(state != BUSY),
        .expire(expire)
    );
    // A timeout closes the cycle like an ack; the error pulse follows one cycle later.
    always_ff @(posedge clk or negedge rst)
        if (!rst) bus_err_o <= 1'b0;
        else bus_err_o <= done && !wb_ack_i;
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE: next = start ? BUSY : IDLE;
            BUSY: next = done ? (|stall_i ? HOLD : IDLE) : BUSY;
            HOLD: next = |stall_i ? HOLD : IDLE;
            default: next = IDLE;
        endcase
        if (flush_i) next = IDLE;
    end
    // rst gating keeps stallreq_o low while reset is held even if a request is pending.
    always_comb begin
        stallreq_o = rst && !flush_i && (start || (state == BUSY && !done));
        cpu_data_o = (!flush_i && state == BUSY && wb_ack_i && !req_q.we) ? wb_data_i :
                     (!flush_i && state == HOLD) ? rd_buf : ZERO_WORD;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            req_q <= '0;
            cyc <= 1'b0;
            rd_buf <= ZERO_WORD;
        end else if (flush_i) begin
            req_q <= '0;
            cyc <= 1'b0;
            rd_buf <= ZERO_WORD;
        end else if (start) begin
            req_q <= '{addr: cpu_addr_i, data: cpu_data_i, sel: cpu_sel_i, we: cpu_we_i};
            cyc <= 1'b1;
        end else if (done) begin
            req_q <= '0;
            cyc <= 1'b0;
            rd_buf <= (wb_ack_i && !req_q.we) ? wb_data_i : ZERO_WORD;
        end
    assign wb_addr_o = req_q.addr;
    assign wb_data_o = req_q.data;
    assign wb_we_o = req_q.we;
    assign wb_sel_o = req_q.sel;
    assign wb_stb_o = cyc;
    assign wb_cyc_o = cyc;
endmodule

// File: tb/tb_dbus_wishbone_if.sv
// tb_dbus_wishbone_if: scoreboarded bench for the data-bus bridge; the timeout case runs when DBUS_TIMEOUT_EN is defined
module tb_dbus_wishbone_if;
    import cpu_defs::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] stall_i = '0;
    logic flush_i = 1'b0, cpu_ce_i = 1'b0, cpu_we_i = 1'b0, wb_ack_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, wb_data_i = '0;
    logic [3:0] cpu_sel_i = '0;
    logic [31:0] cpu_data_o, wb_addr_o, wb_data_o;
    logic stallreq_o, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0] wb_sel_o;
`ifdef DBUS_TIMEOUT_EN
    logic bus_err_o;
`endif
    int n_cmp = 0, n_err = 0;
    logic [31:0] sb[$];

    dbus_wishbone_if #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
`ifdef DBUS_TIMEOUT_EN
        , .bus_err_o(bus_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                       input logic [5:0] stall_ack);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
        sb.push_back(we ? 32'h0 : rdata);
        #1;
        check("req_stall", {31'h0, stallreq_o}, 32'h1);
        check("req_data", cpu_data_o, 32'h0);
        check("req_cyc", {31'h0, wb_cyc_o}, 32'h0);
        tick();
        cpu_ce_i = 1'b0; cpu_we_i = ~we; cpu_addr_i = ~addr; cpu_sel_i = ~sel; cpu_data_i = ~wdata;
        for (int w = 0; w <= waits; w++) begin
            if (w == waits) begin
                wb_ack_i = 1'b1; wb_data_i = rdata; stall_i = stall_ack;
            end else wb_data_i = 32'hBAD0_0000 | w;
            #1;
            check("bus_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
            check("bus_addr", wb_addr_o, addr);
            check("bus_wdata", wb_data_o, wdata);
            check("bus_we_sel", {27'h0, wb_we_o, wb_sel_o}, {27'h0, we, sel});
            if (w < waits) begin
                check("wait_stall", {31'h0, stallreq_o}, 32'h1);
                check("wait_data", cpu_data_o, 32'h0);
            end else begin
                check("ack_stall", {31'h0, stallreq_o}, 32'h0);
                if (sb.size() == 0) check("sb_underflow", 32'h1, 32'h0);
                else check("ack_data", cpu_data_o, sb.pop_front());
            end
            tick();
        end
        wb_ack_i = 1'b0;
        #1;
        check("close_ctl", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        check("close_addr", wb_addr_o, 32'h0);
    endtask

    initial begin
        cpu_ce_i = 1'b1;
        #1;
        check("rst_stall", {31'h0, stallreq_o}, 32'h0);
        check("rst_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rst_data", cpu_data_o, 32'h0);
        tick(); tick();
        rst = 1'b1; cpu_ce_i = 1'b0;
        tick();
        // zero-wait load
        txn(1'b0, 32'h8000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 6'h0);
        // store with three wait states
        txn(1'b1, 32'h0000_0004, 4'b0011, 32'h0000_A5A5, 32'h7777_7777, 3, 6'h0);
        // load acked while the pipeline is stalled elsewhere
        txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'h1234_5678, 1, 6'b000011);
        cpu_ce_i = 1'b1;
        for (int h = 0; h < 3; h++) begin
            if (h == 2) stall_i = 6'h0;
            #1;
            check("hold_state", {30'h0, dut.state}, {30'h0, HOLD});
            check("hold_data", cpu_data_o, 32'h1234_5678);
            check("hold_stall", {31'h0, stallreq_o}, 32'h0);
            check("hold_no_cyc", {31'h0, wb_cyc_o}, 32'h0);
            tick();
        end
        cpu_ce_i = 1'b0;
        #1;
        check("hold_exit", {30'h0, dut.state}, {30'h0, IDLE});
        check("hold_exit_data", cpu_data_o, 32'h0);
        tick();
        // flush in the second BUSY cycle, with an ack that must be discarded
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0200; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        #1;
        check("fl_busy1", {31'h0, stallreq_o}, 32'h1);
        tick();
        flush_i = 1'b1; wb_ack_i = 1'b1; wb_data_i = 32'hCAFE_F00D;
        #1;
        check("fl_stall", {31'h0, stallreq_o}, 32'h0);
        check("fl_data", cpu_data_o, 32'h0);
        tick();
        flush_i = 1'b0; wb_data_i = 32'h5A5A_5A5A;
        #1;
        check("fl_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("fl_late_data", cpu_data_o, 32'h0);
        check("fl_late_stall", {31'h0, stallreq_o}, 32'h0);
        tick();
        wb_ack_i = 1'b0;
        #1;
        check("fl_state", {30'h0, dut.state}, {30'h0, IDLE});
        check("fl_rdbuf", dut.rd_buf, 32'h0);
        tick();
        // asynchronous reset in the middle of a cycle
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'h1; cpu_data_i = 32'h11;
        tick();
        cpu_ce_i = 1'b0;
        #1;
        check("ar_busy", {31'h0, wb_cyc_o}, 32'h1);
        rst = 1'b0;
        #1;
        check("ar_ctl", {29'h0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'h0);
        check("ar_addr", wb_addr_o, 32'h0);
        check("ar_sel_data", {wb_sel_o, wb_data_o[27:0]}, 32'h0);
        check("ar_stall", {31'h0, stallreq_o}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        txn(1'b0, 32'h0000_0020, 4'hC, 32'h0, 32'h5555_AAAA, 1, 6'h0);
`ifdef DBUS_TIMEOUT_EN
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            check("to_cyc", {31'h0, wb_cyc_o}, 32'h1);
            check("to_stall", {31'h0, stallreq_o}, c < 8 ? 32'h1 : 32'h0);
            check("to_data", cpu_data_o, 32'h0);
            check("to_err_early", {31'h0, bus_err_o}, 32'h0);
            tick();
        end
        #1;
        check("to_closed", {31'h0, wb_cyc_o}, 32'h0);
        check("to_err", {31'h0, bus_err_o}, 32'h1);
        tick();
        #1;
        check("to_err_pulse", {31'h0, bus_err_o}, 32'h0);
        check("to_state", {30'h0, dut.state}, {30'h0, IDLE});
`endif
        check("sb_left", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
